lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
Load/store unit sitting directly downstream of the core's data-memory port: DataAdr, WriteData, the MemWrite/MemRead strobes and funct3.
- Core side: the single-cycle access is converted into a valid/ready request plus a response on a variable-latency data bus.
- Bus side: generates byte enables and lane-replicated store data; extracts and sign/zero-extends load data.
- Stalls the core until the access completes, is rejected as misaligned, or times out.

Parameters:
TIMEOUT, 64, cycles allowed in REQ+WAIT before aborting with bus_err (≥2)
CNT_W, 7, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  MemRead|MemWrite from core; held stable while stall=1
core_we  in  1  1=store, 0=load
core_addr  in  32  byte address (ALUResult)
core_wdata  in  32  store data (rs2)
core_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
stall  out  1  freeze PC/regfile write
core_rdata  out  32  extended load result, valid while state=DONE
misalign_err  out  1  one-cycle pulse in DONE
bus_err  out  1  one-cycle pulse in DONE on timeout
bus_valid  out  1  request valid
bus_ready  in  1  slave accepts when bus_valid&bus_ready
bus_we  out  1  write request
bus_addr  out  32  {core_addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rvalid  in  1  read response valid
bus_rdata  in  32  read response word

Behaviour:
- States: IDLE, REQ, WAIT, DONE; registered state, 2-bit encoding.
- Reset (reset=0, async): state=IDLE, counter=0, captured data=0; bus_valid=0, core_rdata=0, misalign_err=0, bus_err=0. Any in-flight transaction is abandoned and bus_valid drops immediately.
- stall = core_req & (state != DONE), combinational; it is 0 in DONE.
- IDLE:
  - core_req=1 and aligned → REQ.
  - core_req=1 and misaligned → DONE with misalign flag; no bus activity.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - funct3 values 011, 110, 111 are treated as misaligned.
- REQ:
  - bus_valid=1; bus_addr, bus_be, bus_wdata, bus_we driven combinationally from core inputs (held stable by stall).
  - On bus_valid&bus_ready: store → DONE; load → WAIT.
- WAIT: bus_valid=0. On bus_rvalid: capture bus_rdata → DONE. bus_rvalid in any other state is ignored. Earliest response is the cycle after acceptance.
- DONE: exactly one cycle; core_rdata/err flags valid; → IDLE unconditionally. Back-to-back accesses cost one IDLE cycle each (min load 4 cycles including DONE, min store 3).
- Timeout:
  - Counter clears on IDLE→REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without completion → DONE with bus_err=1, core_rdata=0; bus_valid drops.
  - If completion and timeout fall in the same cycle, completion wins.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - Loads drive the same mask.
- Store data: byte replicated ×4, half ×2, word as-is.
- Load extract: select lane by addr[1:0]; funct3 000/001 sign-extend, 100/101 zero-extend, 010 pass through. Misaligned or error → core_rdata=0.
- core_rdata held 0 outside DONE.

Decomposition:
- Shared package lsu_pkg: state enum (IDLE, REQ, WAIT, DONE); funct3 size constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- One sub-module, lsu_align: purely combinational.
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, replicated wdata, extended rdata, misaligned.
- FSM and counter remain in lsu_bus_bridge.

Test Plan:
- Stored byte: core_req=1, we=1, funct3=000, addr=0x103, wdata=0xAB, bus_ready=1 on first REQ cycle → bus_addr=0x100, bus_be=1000, bus_wdata=0xABABABAB; stall high 2 cycles, DONE on cycle 3.
- Load halfword signed: addr=0x102, funct3=001, bus_rdata=0x8001_1234 returned 3 cycles after accept → core_rdata=0xFFFF8001 in DONE, bus_be=1100.
- Load byte unsigned, same data, addr=0x103, funct3=100 → core_rdata=0x00000080.
- Misaligned word load at addr=0x102 → no bus_valid ever; DONE next cycle with misalign_err=1, core_rdata=0.
- Timeout: TIMEOUT=8, bus_ready held 0 → bus_valid high 8 cycles, then DONE with bus_err=1, stall drops.
- Reset mid-operation: reset=0 asserted during WAIT → bus_valid, stall-derived state and flags clear immediately. A late bus_rvalid after reset release is ignored; the next core_req starts in IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and funct3 access-size constants for the LSU bridge
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable, store-lane replication and load extraction for one access
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] lane;

  // Lane-align the response word so the addressed byte/half sits at bit 0.
  assign lane = rdata >> {addr, 3'b000};

  // Decode access size: mask, replicated store data, extended load data, alignment.
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane[7]}}, lane[7:0]};
      end
      F3_LBU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, lane[7:0]};
      end
      F3_LH: begin
        misaligned = addr[0];
        be         = 4'b0011 << addr;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{lane[15]}}, lane[15:0]};
      end
      F3_LHU: begin
        misaligned = addr[0];
        be         = 4'b0011 << addr;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, lane[15:0]};
      end
      F3_LW: begin
        misaligned = (addr != 2'b00);
        be         = 4'b1111;
        rdata_ext  = rdata;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - converts single-cycle core data accesses into valid/ready bus transactions
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        stall,
  output logic [31:0] core_rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             mis_q;
  logic             berr_q;
  logic [31:0]      rdata_ext;
  logic             misaligned;
  logic             timeout_hit;

  lsu_align u_align (
    .funct3     (core_funct3),
    .addr       (core_addr[1:0]),
    .wdata      (core_wdata),
    .rdata      (bus_rdata),
    .be         (bus_be),
    .wdata_rep  (bus_wdata),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign stall        = core_req & (state_q != DONE);
  assign bus_valid    = (state_q == REQ);
  assign bus_we       = (state_q == REQ) & core_we;
  assign bus_addr     = {core_addr[31:2], 2'b00};
  assign core_rdata   = (state_q == DONE) ? rdata_q : 32'h0;
  assign misalign_err = (state_q == DONE) & mis_q;
  assign bus_err      = (state_q == DONE) & berr_q;

  // Next-state logic; completion is tested before timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (core_req) state_d = misaligned ? DONE : REQ;
      end
      REQ: begin
        if (bus_ready)        state_d = core_we ? DONE : WAIT;
        else if (timeout_hit) state_d = DONE;
      end
      WAIT: begin
        if (bus_rvalid || timeout_hit) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Timeout counter plus the result/flags presented during DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          rdata_q <= 32'h0;
          berr_q  <= 1'b0;
          mis_q   <= core_req & misaligned;
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!bus_ready && timeout_hit) berr_q <= 1'b1;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_rvalid)       rdata_q <= rdata_ext;
          else if (timeout_hit) berr_q  <= 1'b1;
        end
        default: begin
          rdata_q <= 32'h0;
          mis_q   <= 1'b0;
          berr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb/tb_lsu_bus_bridge.sv - self-checking bench for lsu_bus_bridge
module tb_lsu_bus_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        stall;
  logic [31:0] core_rdata;
  logic        misalign_err, bus_err;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_funct3  (core_funct3),
    .stall        (stall),
    .core_rdata   (core_rdata),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          r;
    int          d;
    logic [31:0] rd;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_err;
    int          exp_stall;
    int          exp_nvalid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int a, input int s);
    logic [3:0] m = 4'b0;
    for (int i = 0; i < 4; i++) if (i >= a && i < a + s) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input int s);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) v = v | (((w >> (8 * (i % s))) & 32'hFF) << (8 * i));
    return v;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] rd, input int a, input logic [2:0] f3);
    logic [31:0] v;
    int s = acc_size(f3);
    v = rd >> (8 * a);
    if (s == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One core access with a slave that accepts after r refused REQ cycles and
  // answers loads d cycles after acceptance.
  task automatic run_txn(input vec_t v, input string tag);
    int cyc = 0, acc = -1, nvalid = 0;
    bit done = 0;
    @(negedge clk);
    core_req = 1'b1; core_we = v.we; core_addr = v.addr;
    core_wdata = v.wdata; core_funct3 = v.f3;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    while (!done && cyc < 40) begin
      #1;
      if (!stall) begin
        done = 1;
        chk({tag, "_stall_cycles"}, cyc, v.exp_stall);
        chk({tag, "_nvalid"}, nvalid, v.exp_nvalid);
        chk({tag, "_misalign"}, {31'h0, misalign_err}, {31'h0, v.exp_mis});
        chk({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, v.exp_err});
        chk({tag, "_rdata"}, core_rdata, v.exp_rdata);
      end else begin
        bus_ready = 1'b0;
        if (bus_valid) begin
          if (nvalid == 0) begin
            chk({tag, "_bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
            chk({tag, "_bus_be"}, {28'h0, bus_be}, {28'h0, v.exp_be});
            chk({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, v.we});
            if (v.we) chk({tag, "_bus_wdata"}, bus_wdata, v.exp_wdata);
          end
          if (nvalid == v.r) begin
            bus_ready = 1'b1;
            acc = cyc;
          end
          nvalid++;
        end
        bus_rvalid = (acc >= 0) && (cyc == acc + v.d);
        bus_rdata  = bus_rvalid ? v.rd : $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_txn_timeout: no DONE within %0d cycles", tag, cyc);
    end
    core_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  function automatic vec_t model_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, input int r, input int d, input logic [31:0] rd);
    vec_t v;
    int a = int'(addr[1:0]);
    int s = acc_size(f3);
    int t;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.r = r; v.d = d; v.rd = rd;
    v.exp_mis = (s == 0) || (a % s != 0);
    v.exp_be = (s == 0) ? 4'b0 : model_be(a, s);
    v.exp_wdata = (s == 0) ? wdata : model_wdata(wdata, s);
    v.exp_err = 1'b0;
    v.exp_rdata = 32'h0;
    if (v.exp_mis) begin
      v.exp_stall = 1; v.exp_nvalid = 0;
    end else begin
      t = we ? r + 1 : r + 1 + d;
      if (r + 1 > TO) begin
        v.exp_err = 1'b1; v.exp_nvalid = TO; v.exp_stall = 1 + TO;
      end else if (t > TO) begin
        v.exp_err = 1'b1; v.exp_nvalid = r + 1; v.exp_stall = 1 + TO;
      end else begin
        v.exp_nvalid = r + 1; v.exp_stall = 1 + t;
        if (!we) v.exp_rdata = model_rdata(rd, a, f3);
      end
    end
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 32'h103, 32'h0000_00AB, 3'b000, 0, 1, 32'h0,        32'h0,        4'b1000, 32'hABAB_ABAB, 1'b0, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 32'h102, 32'h0,         3'b001, 0, 3, 32'h8001_1234, 32'hFFFF_8001, 4'b1100, 32'h0,         1'b0, 1'b0, 5, 1};
    vecs[2]  = '{1'b0, 32'h103, 32'h0,         3'b100, 0, 3, 32'h8001_1234, 32'h0000_0080, 4'b1000, 32'h0,         1'b0, 1'b0, 5, 1};
    vecs[3]  = '{1'b0, 32'h102, 32'h0,         3'b010, 0, 1, 32'h5555_5555, 32'h0,        4'b1111, 32'h0,         1'b1, 1'b0, 1, 0};
    vecs[4]  = '{1'b1, 32'h200, 32'hCAFE_F00D, 3'b010, 20, 1, 32'h0,       32'h0,        4'b1111, 32'hCAFE_F00D, 1'b0, 1'b1, 9, 8};
    vecs[5]  = '{1'b0, 32'h300, 32'h0,         3'b010, 2, 5, 32'h1234_5678, 32'h1234_5678, 4'b1111, 32'h0,         1'b0, 1'b0, 9, 3};
    vecs[6]  = '{1'b0, 32'h300, 32'h0,         3'b010, 2, 6, 32'h1234_5678, 32'h0,        4'b1111, 32'h0,         1'b0, 1'b1, 9, 3};
    vecs[7]  = '{1'b0, 32'h101, 32'h0,         3'b001, 0, 1, 32'h1111_1111, 32'h0,        4'b0110, 32'h0,         1'b1, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 32'h100, 32'h1,         3'b011, 0, 1, 32'h0,        32'h0,        4'b0000, 32'h0,         1'b1, 1'b0, 1, 0};
    vecs[9]  = '{1'b1, 32'h102, 32'h1234_ABCD, 3'b001, 1, 1, 32'h0,        32'h0,        4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 3, 2};
    vecs[10] = '{1'b0, 32'h101, 32'h0,         3'b000, 0, 1, 32'h0000_F500, 32'hFFFF_FFF5, 4'b0010, 32'h0,         1'b0, 1'b0, 3, 1};
    vecs[11] = '{1'b0, 32'h100, 32'h0,         3'b101, 0, 2, 32'hAAAA_8765, 32'h0000_8765, 4'b0011, 32'h0,         1'b0, 1'b0, 4, 1};

    reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0;
    core_wdata = 32'h0; core_funct3 = 3'b010; bus_ready = 1'b0;
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_flags", {30'h0, misalign_err, bus_err}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while a load waits for its response.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_funct3 = 3'b010;
    bus_ready = 1'b1;
    @(negedge clk);
    chk("mid_req_valid", {31'h0, bus_valid}, 32'h1);
    @(negedge clk);
    bus_ready = 1'b0;
    #1 chk("mid_wait_valid", {31'h0, bus_valid}, 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, bus_valid}, 32'h0);
    chk("mid_rst_flags", {30'h0, misalign_err, bus_err}, 32'h0);
    chk("mid_rst_rdata", core_rdata, 32'h0);
    core_req = 1'b0;
    #1 chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("late_rvalid_rdata", core_rdata, 32'h0);
    chk("late_rvalid_valid", {31'h0, bus_valid}, 32'h0);
    chk("late_rvalid_stall", {31'h0, stall}, 32'h0);
    run_txn(vecs[1], "post_rst");

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] f3_pick;
      f3_pick = $urandom_range(0, 9);
      case (f3_pick)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        8:       f3 = 3'b110;
        default: f3 = 3'b010;
      endcase
      run_txn(model_vec($urandom_range(0, 1) == 1, $urandom, $urandom, f3,
                        $urandom_range(0, 9), $urandom_range(1, 8), $urandom),
              $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
